// File: rtl/ex_wb_stage.sv
// Execute stage of the 8-bit pipeline: ID/EX and EX/WB registers, forwarded
// operand select, ADD/SHL execution and the register-file writeback port.

module ex_wb_stage_checker #(
  parameter logic [7:0] BUBBLE_IC = 8'hC0
) (
  input logic       clk,
  input logic       reset,
  input logic       stall,
  input logic       wb_en,
  input logic [7:0] id_ex_ic,
  input logic [7:0] ex_wb_ic,
  input logic [2:0] wb_addr
);

  a_no_write_while_stalled: assert property (
    @(posedge clk) disable iff (reset) wb_en |-> !stall);

  a_wb_addr_is_rd: assert property (
    @(posedge clk) disable iff (reset) wb_addr == ex_wb_ic[5:3]);

  a_reset_bubbles: assert property (
    @(posedge clk) $past(reset) |-> (id_ex_ic == BUBBLE_IC && ex_wb_ic == BUBBLE_IC));

endmodule

module ex_wb_stage #(
  parameter int         DATA_W    = 8,
  parameter logic [7:0] BUBBLE_IC = 8'hC0,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [7:0]        id_ic,
  input  logic [DATA_W-1:0] id_rd_data,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        forward_signal,
  output logic [7:0]        id_ex_ic,
  output logic [7:0]        ex_wb_ic,
  output logic [DATA_W-1:0] ex_wb_result,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] FWD_RD = 2'b01;
  localparam logic [1:0] FWD_RS = 2'b10;

  logic [7:0]        id_ex_ic_r;
  logic [DATA_W-1:0] id_ex_rd_data_r;
  logic [DATA_W-1:0] id_ex_rs_data_r;
  logic [7:0]        ex_wb_ic_r;
  logic [DATA_W-1:0] ex_wb_result_r;
  logic              zero_flag_r;
  logic [CNT_W-1:0]  retire_count_r;

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] result_s;
  logic              wb_en_s;

  function automatic logic is_writer(input logic [7:0] ic);
    return (ic[7:6] == OP_ADD) || (ic[7:6] == OP_SHL);
  endfunction

  // ID/EX register: flush beats stall, an empty issue slot becomes a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_ic_r      <= BUBBLE_IC;
      id_ex_rd_data_r <= {DATA_W{1'b0}};
      id_ex_rs_data_r <= {DATA_W{1'b0}};
    end else if (flush) begin
      id_ex_ic_r      <= BUBBLE_IC;
      id_ex_rd_data_r <= {DATA_W{1'b0}};
      id_ex_rs_data_r <= {DATA_W{1'b0}};
    end else if (stall) begin
      id_ex_ic_r      <= id_ex_ic_r;
      id_ex_rd_data_r <= id_ex_rd_data_r;
      id_ex_rs_data_r <= id_ex_rs_data_r;
    end else if (id_valid) begin
      id_ex_ic_r      <= id_ic;
      id_ex_rd_data_r <= id_rd_data;
      id_ex_rs_data_r <= id_rs_data;
    end else begin
      id_ex_ic_r      <= BUBBLE_IC;
      id_ex_rd_data_r <= {DATA_W{1'b0}};
      id_ex_rs_data_r <= {DATA_W{1'b0}};
    end
  end

  // Operand select; a self-dependent rd==rs instruction gets the forward on both operands
  always_comb begin
    op_a_s = id_ex_rd_data_r;
    op_b_s = id_ex_rs_data_r;
    case (forward_signal)
      FWD_RD: begin
        op_a_s = ex_wb_result_r;
        if (id_ex_ic_r[5:3] == id_ex_ic_r[2:0]) begin
          op_b_s = ex_wb_result_r;
        end else begin
          op_b_s = id_ex_rs_data_r;
        end
      end
      FWD_RS: begin
        op_b_s = ex_wb_result_r;
      end
      default: begin
        op_a_s = id_ex_rd_data_r;
        op_b_s = id_ex_rs_data_r;
      end
    endcase
  end

  // Execute: carry out of ADD and bits shifted past the MSB are dropped
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (id_ex_ic_r[7:6])
      OP_ADD:  result_s = op_a_s + op_b_s;
      OP_SHL:  result_s = op_a_s << id_ex_ic_r[2:0];
      default: result_s = {DATA_W{1'b0}};
    endcase
  end

  // EX/WB register: unaffected by flush, frozen by stall
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_wb_ic_r     <= BUBBLE_IC;
      ex_wb_result_r <= {DATA_W{1'b0}};
    end else if (stall) begin
      ex_wb_ic_r     <= ex_wb_ic_r;
      ex_wb_result_r <= ex_wb_result_r;
    end else begin
      ex_wb_ic_r     <= id_ex_ic_r;
      ex_wb_result_r <= result_s;
    end
  end

  // Write enable; held off while stalled so a frozen writer commits once on release
  always_comb begin
    wb_en_s = 1'b0;
    if (is_writer(ex_wb_ic_r) && !stall && !reset) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
  end

  // Retire counter and zero flag track only committed writes
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_r <= {CNT_W{1'b0}};
      zero_flag_r    <= 1'b0;
    end else if (wb_en_s) begin
      retire_count_r <= retire_count_r + CNT_W'(1);
      zero_flag_r    <= (ex_wb_result_r == {DATA_W{1'b0}});
    end else begin
      retire_count_r <= retire_count_r;
      zero_flag_r    <= zero_flag_r;
    end
  end

  assign id_ex_ic     = id_ex_ic_r;
  assign ex_wb_ic     = ex_wb_ic_r;
  assign ex_wb_result = ex_wb_result_r;
  assign wb_en        = wb_en_s;
  assign wb_addr      = ex_wb_ic_r[5:3];
  assign wb_data      = ex_wb_result_r;
  assign zero_flag    = zero_flag_r;
  assign retire_count = retire_count_r;

  ex_wb_stage_checker #(.BUBBLE_IC(BUBBLE_IC)) u_checker (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .wb_en    (wb_en_s),
    .id_ex_ic (id_ex_ic_r),
    .ex_wb_ic (ex_wb_ic_r),
    .wb_addr  (ex_wb_ic_r[5:3])
  );

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: the bench plays register file and forwarding unit,
// an architectural model predicts every register write in program order.

module tb_ex_wb_stage;

  localparam int         DATA_W = 8;
  localparam int         CNT_W  = 16;
  localparam logic [7:0] BUBBLE = 8'hC0;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [7:0]        id_ic;
  logic [DATA_W-1:0] id_rd_data;
  logic [DATA_W-1:0] id_rs_data;
  logic              stall;
  logic              flush;
  logic [1:0]        forward_signal;
  logic [7:0]        id_ex_ic;
  logic [7:0]        ex_wb_ic;
  logic [DATA_W-1:0] ex_wb_result;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic [CNT_W-1:0]  retire_count;

  always #5 clk = ~clk;

  ex_wb_stage #(.DATA_W(DATA_W), .BUBBLE_IC(BUBBLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ic(id_ic),
    .id_rd_data(id_rd_data), .id_rs_data(id_rs_data), .stall(stall), .flush(flush),
    .forward_signal(forward_signal), .id_ex_ic(id_ex_ic), .ex_wb_ic(ex_wb_ic),
    .ex_wb_result(ex_wb_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .zero_flag(zero_flag), .retire_count(retire_count)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rf [8];         // environment register file, written from the DUT port
  logic [7:0]  spec [8];       // architectural state including executed, uncommitted ops
  logic [7:0]  committed [8];  // architectural state of writes already seen at the port
  wr_t         exp_q [$];
  logic        slot_v = 1'b0;  // one instruction issued but not yet executed
  logic [7:0]  slot_ic = 8'h00;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_zero = 1'b0;
  logic        prev_rst = 1'b0;

  function automatic bit writer(input logic [7:0] ic);
    return (ic[7:6] == 2'b00) || (ic[7:6] == 2'b01);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] read_reg(input logic [2:0] r);
    if (wb_en === 1'b1 && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  task automatic step(input bit rst, input bit stl, input bit fl, input bit v,
                      input logic [7:0] ic);
    logic [1:0] fwd;
    logic [7:0] res;
    @(negedge clk);
    reset    = rst;
    stall    = stl;
    flush    = fl;
    id_valid = v;
    id_ic    = ic;
    #1;
    // forwarding unit: the instruction now in EX/WB has not reached the register file
    fwd = 2'b00;
    if (writer(ex_wb_ic) && ex_wb_ic[5:3] == id_ex_ic[5:3]) fwd = 2'b01;
    else if (writer(ex_wb_ic) && id_ex_ic[7:6] == 2'b00 && ex_wb_ic[5:3] == id_ex_ic[2:0]) fwd = 2'b10;
    if (fwd == 2'b00 && $urandom_range(0, 1) == 1) fwd = 2'b11;
    forward_signal = fwd;
    // an operand that will be forwarded gets junk, as a real stale read would
    id_rd_data = read_reg(ic[5:3]);
    id_rs_data = read_reg(ic[2:0]);
    if (slot_v && writer(slot_ic) && slot_ic[5:3] == ic[5:3]) id_rd_data = 8'($urandom);
    if (slot_v && writer(slot_ic) && slot_ic[5:3] == ic[2:0]) id_rs_data = 8'($urandom);
    // architectural model for the coming edge
    if (rst) begin
      exp_q.delete();
      slot_v = 1'b0;
      spec = committed;
    end else if (stl) begin
      if (fl) slot_v = 1'b0;
    end else begin
      if (slot_v && writer(slot_ic)) begin
        if (slot_ic[7:6] == 2'b00) res = spec[slot_ic[5:3]] + spec[slot_ic[2:0]];
        else res = spec[slot_ic[5:3]] << slot_ic[2:0];
        spec[slot_ic[5:3]] = res;
        exp_q.push_back('{addr: slot_ic[5:3], data: res});
      end
      slot_v  = v && !fl;
      slot_ic = ic;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // monitor: samples late in the cycle, pops the scoreboard on every write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #3;
      check("retire_count", 32'(retire_count), 32'(exp_cnt));
      check("zero_flag", 32'(zero_flag), 32'(exp_zero));
      if (prev_rst) begin
        check("id_ex_ic_after_reset", 32'(id_ex_ic), 32'(BUBBLE));
        check("ex_wb_ic_after_reset", 32'(ex_wb_ic), 32'(BUBBLE));
      end
      if (reset) begin
        check("wb_en_in_reset", 32'(wb_en), 32'd0);
      end else if (stall) begin
        check("wb_en_while_stalled", 32'(wb_en), 32'd0);
      end else if (wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=%h required=no write",
                   wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(wb_addr), 32'(e.addr));
          check("wb_data", 32'(wb_data), 32'(e.data));
          rf[wb_addr] = wb_data;
          committed[e.addr] = e.data;
          exp_cnt++;
          exp_zero = (e.data == 8'h00);
        end
      end
      if (reset) begin
        exp_cnt  = 16'd0;
        exp_zero = 1'b0;
      end
      prev_rst = reset;
    end
  end

  initial begin
    logic [7:0] ic;
    logic [1:0] op;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_ic = 8'h00;
    id_rd_data = 8'h00; id_rs_data = 8'h00; forward_signal = 2'b00;
    rf[0] = 8'h80; rf[1] = 8'h05; rf[2] = 8'h03; rf[3] = 8'h7F;
    rf[4] = 8'h07; rf[5] = 8'h80; rf[6] = 8'h01; rf[7] = 8'h80;
    spec = rf;
    committed = rf;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // dependent pairs: rs forward, SHL rd forward, self-dependent wrap, 80+80
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h21);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h2E);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h69);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h1F);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h1B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle(3);
    check("add_r1", 32'(rf[1]), 32'h08);
    check("add_fwd_rs_r4", 32'(rf[4]), 32'h0F);
    check("shl_fwd_rd_r5", 32'(rf[5]), 32'h02);
    check("add_self_wrap_r3", 32'(rf[3]), 32'hFE);
    check("add_80_80_r0", 32'(rf[0]), 32'h00);
    check("zero_flag_set", 32'(zero_flag), 32'd1);
    check("retire_after_7", 32'(retire_count), 32'd7);

    // stall+flush together squashes the ID/EX op and freezes the EX/WB writer
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h3F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("stall_flush_id_ex", 32'(id_ex_ic), 32'(BUBBLE));
    check("stall_flush_ex_wb_hold", 32'(ex_wb_ic), 32'h0A);
    check("stall_no_write", 32'(wb_en), 32'd0);
    idle(3);
    check("held_writer_r1", 32'(rf[1]), 32'h0B);
    check("squashed_r2", 32'(rf[2]), 32'h03);
    check("retire_once", 32'(retire_count), 32'd8);

    // non-writing ops and an invalid issue slot
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1, BUBBLE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h0A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h9B);
    idle(3);
    check("nonwrite_retire", 32'(retire_count), 32'd9);
    check("nonwrite_zero_hold", 32'(zero_flag), 32'd1);
    check("invalid_not_run_r1", 32'(rf[1]), 32'h0B);

    // reset with writers in flight discards them
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h0A);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_retire_zero", 32'(retire_count), 32'd0);
    check("reset_discard_r1", 32'(rf[1]), 32'h0B);
    check("reset_discard_r2", 32'(rf[2]), 32'h03);

    // randomized traffic with dense register reuse
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: op = 2'b00;
          4, 5, 6, 7: op = 2'b01;
          8:          op = 2'b10;
          default:    op = 2'b11;
        endcase
        ic[7:6] = op;
        ic[5:3] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        ic[2:0] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        step(1'b0, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 85), ic);
      end
    end

    idle(4);
    @(negedge clk);
    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute stage of the 8-bit pipeline, holding the ID/EX and EX/WB pipeline registers.
- Presents ID_EX_IC and EX_WB_IC to the forwarding unit and takes back its 2-bit forward_signal.
- Uses forward_signal to select operands, executes the instruction, and drives the register-file writeback port.
- Instruction format: [7:6] opcode, [5:3] rd, [2:0] rs/imm.

Parameters:
- DATA_W, 8, datapath width.
- BUBBLE_IC, 8'hC0, non-writing NOP encoding (opcode 11) inserted on reset, flush and empty issue.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  instruction from ID is valid this cycle.
- id_ic  in  8  instruction from ID.
- id_rd_data  in  DATA_W  register-file read of rd, taken in ID.
- id_rs_data  in  DATA_W  register-file read of rs, taken in ID.
- stall  in  1  freeze both pipeline registers.
- flush  in  1  squash the instruction in ID/EX.
- forward_signal  in  2  from forwarding unit: 00 none, 01 rd from EX/WB, 10 rs from EX/WB.
- id_ex_ic  out  8  ID/EX instruction register, to forwarding unit.
- ex_wb_ic  out  8  EX/WB instruction register, to forwarding unit.
- ex_wb_result  out  DATA_W  EX/WB result register; also the forwarding source.
- wb_en  out  1  register-file write enable.
- wb_addr  out  3  write address, = ex_wb_ic[5:3].
- wb_data  out  DATA_W  write data, = ex_wb_result.
- zero_flag  out  1  registered: last writing result == 0.
- retire_count  out  CNT_W  count of writing instructions retired.

Behaviour:
- Reset (synchronous, on clk with reset=1):
  - id_ex_ic and ex_wb_ic = BUBBLE_IC.
  - ID/EX operand registers = 0, ex_wb_result = 0.
  - zero_flag = 0, retire_count = 0, wb_en = 0.
  - Reset mid-operation discards all in-flight instructions; no write occurs in the reset cycle.
- ID/EX register update, per clk:
  - flush: load BUBBLE_IC.
  - else stall: hold.
  - else id_valid: load id_ic, id_rd_data, id_rs_data.
  - else: load BUBBLE_IC.
  - flush has priority over stall.
- Operand select (combinational, EX):
  - opA = ex_wb_result if forward_signal==01, else ID/EX rd data.
  - opB = ex_wb_result if forward_signal==10, else ID/EX rs data.
  - When forward_signal==01 and id_ex_ic[5:3]==id_ex_ic[2:0], opB also takes ex_wb_result (the forwarding unit reports only 01 in this case).
  - forward_signal==11 is treated as 00.
- Execute:
  - Opcode 00 ADD: result = (opA + opB) mod 2^DATA_W; carry dropped.
  - Opcode 01 SHL: result = opA << imm[2:0], zero-fill; shift amount 0 passes opA unchanged.
  - Opcodes 10 and 11: no register write; result = 0.
- EX/WB register update, per clk:
  - stall: hold ex_wb_ic and ex_wb_result.
  - else: load id_ex_ic and result.
  - A flush in the same cycle does not affect EX/WB; the instruction already in ID/EX moves on.
- Writeback (combinational):
  - wb_en = 1 when ex_wb_ic[7:6] is 00 or 01 and stall==0.
  - A stalled writer writes exactly once, in the first cycle after stall deasserts.
- Retire and flags, updated on each clk edge where wb_en==1:
  - retire_count += 1, wrapping from 2^CNT_W-1 to 0.
  - zero_flag = (ex_wb_result==0).
  - Otherwise both hold.
- Latency:
  - id_ic accepted at edge N appears in ex_wb_ic at edge N+1.
  - Its write is visible to a register-file read in the cycle after edge N+1.
  - Back-to-back dependents resolve through forwarding with no stall.

Test Plan:
- Reset check: assert reset for 2 cycles mid-stream → id_ex_ic=ex_wb_ic=8'hC0, wb_en=0, retire_count=0 on the first edge; no write in the reset cycle.
- ADD forward on rs: r1=5, r2=3. ADD r1,r2 (8'h0A) then ADD r4,r1 (8'h21) with forward_signal=10 and id_rs_data=stale 0 → second result = r4+8; wb_addr=4.
- SHL forward on rd: ADD result 8'h81 in EX/WB, then SHL rd,1 on the same rd with forward_signal=01 → result 8'h02 (bit 7 dropped); retire_count increments by 2.
- ADD wrap and self-dependency: ADD result 8'hFF in EX/WB, then ADD r3,r3 with forward_signal=01 → opA=opB=FF, result 8'hFE; zero_flag=0. Separately, 8'h80+8'h80 → 8'h00 and zero_flag=1.
- Stall and flush together: stall=1 and flush=1 in the same cycle → ID/EX becomes 8'hC0, EX/WB holds, wb_en=0. After release, the held writer writes exactly once.
- Non-writing ops: opcode 10 and 8'hC0 bubbles → wb_en=0; retire_count and zero_flag unchanged. Issue with id_valid=0 → bubble inserted.
